// File: rtl/display_arbiter.sv
// display_arbiter: shares the six-digit seven-segment bus between the CPU PIOs
// (default owner) and a hardware requester (alarm/timer). Ownership changes are
// separated by blank gaps, and a granted HW source keeps the display for at
// least HOLD_CYCLES cycles.
//
// Optional feature: define DISPLAY_ARB_BLINK_EN to blink the HW digits with a
// BLINK_HALF half-period while HW owns the display. Without it, HW digits are
// shown steadily and no blink counter exists.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   cpu_digits - CPU digit bus, digit 0 in bits [3:0]
//   cpu_lock   - 1 blocks a new HW takeover (never preempts an active grant)
//   hw_req     - level request from the HW source
//   hw_digits  - HW digit bus, same packing as cpu_digits
//   hw_grant   - 1 while HW owns the display
//   owner      - 0 = CPU or gap, 1 = HW active
//   digits_out - registered bus to the display drivers
module display_arbiter #(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [3:0]  BLANK_CODE  = 4'hF,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIGITS*4-1:0]   cpu_digits,
  input  logic                  cpu_lock,
  input  logic                  hw_req,
  input  logic [DIGITS*4-1:0]   hw_digits,
  output logic                  hw_grant,
  output logic                  owner,
  output logic [DIGITS*4-1:0]   digits_out
);

  localparam int unsigned BUS_W   = DIGITS * 4;
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HG > BLINK_HALF) ? MAX_HG : BLINK_HALF;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [BUS_W-1:0] BLANK   = {DIGITS{BLANK_CODE}};

  localparam logic [1:0] ST_CPU_OWN    = 2'd0;
  localparam logic [1:0] ST_GAP_TO_HW  = 2'd1;
  localparam logic [1:0] ST_HW_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_GAP_TO_CPU = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             grant_q,    grant_d;
  logic             owner_q,    owner_d;
  logic [BUS_W-1:0] digits_q,   digits_d;

`ifdef DISPLAY_ARB_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_M1 = CNT_W'(BLINK_HALF - 1);
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_vis_q, blink_vis_d;
`endif

  // Next-state, counter and output-bus selection.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    digits_d   = digits_q;
`ifdef DISPLAY_ARB_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
`endif
    case (state_q)
      ST_CPU_OWN: begin
        digits_d = cpu_digits;
        if (hw_req && !cpu_lock) begin
          state_d   = ST_GAP_TO_HW;
          gap_cnt_d = GAP_M1;
        end
      end
      ST_GAP_TO_HW: begin
        digits_d = BLANK;
        // A request withdrawn during the gap is dropped, not deferred.
        if (!hw_req) begin
          state_d   = ST_GAP_TO_CPU;
          gap_cnt_d = GAP_M1;
        end else if (gap_cnt_q == '0) begin
          state_d    = ST_HW_ACTIVE;
          grant_d    = 1'b1;
          owner_d    = 1'b1;
          hold_cnt_d = HOLD_M1;
`ifdef DISPLAY_ARB_BLINK_EN
          blink_cnt_d = BLINK_M1;
          blink_vis_d = 1'b1;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      ST_HW_ACTIVE: begin
`ifdef DISPLAY_ARB_BLINK_EN
        digits_d = blink_vis_q ? hw_digits : BLANK;
        if (blink_cnt_q == '0) begin
          blink_cnt_d = BLINK_M1;
          blink_vis_d = ~blink_vis_q;
        end else begin
          blink_cnt_d = blink_cnt_q - CNT_W'(1);
        end
`else
        digits_d = hw_digits;
`endif
        hold_cnt_d = (hold_cnt_q == '0) ? '0 : hold_cnt_q - CNT_W'(1);
        if ((hold_cnt_q == '0) && !hw_req) begin
          state_d   = ST_GAP_TO_CPU;
          gap_cnt_d = GAP_M1;
          grant_d   = 1'b0;
          owner_d   = 1'b0;
        end
      end
      ST_GAP_TO_CPU: begin
        digits_d = BLANK;
        if (gap_cnt_q == '0) begin
          state_d = ST_CPU_OWN;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_CPU_OWN;
        digits_d = BLANK;
        grant_d  = 1'b0;
        owner_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns straight to CPU ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CPU_OWN;
      gap_cnt_q  <= '0;
      hold_cnt_q <= '0;
      grant_q    <= 1'b0;
      owner_q    <= 1'b0;
      digits_q   <= BLANK;
`ifdef DISPLAY_ARB_BLINK_EN
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      digits_q   <= digits_d;
`ifdef DISPLAY_ARB_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
`endif
    end
  end

  assign hw_grant   = grant_q;
  assign owner      = owner_q;
  assign digits_out = digits_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with HOLD_CYCLES=8, GAP_CYCLES=2, BLINK_HALF=4.
// Directed stimulus; an abstract phase/duration model predicts outputs every
// cycle, and literal expectations pin the model on key cycles.
module tb_display_arbiter;

  localparam int W        = 24;
  localparam int HOLD     = 8;
  localparam int GAP      = 2;
  localparam int BHALF    = 4;
  localparam logic [W-1:0] BLANK  = 24'hFFFFFF;
  localparam logic [W-1:0] HW_PAT = 24'hABCDEF;
`ifdef DISPLAY_ARB_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] cpu_digits = 24'h123456;
  logic         cpu_lock = 1'b0;
  logic         hw_req = 1'b0;
  logic [W-1:0] hw_digits = HW_PAT;
  logic         hw_grant;
  logic         owner;
  logic [W-1:0] digits_out;

  int checks = 0;
  int failures = 0;

  display_arbiter #(
    .DIGITS(6), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .BLANK_CODE(4'hF), .BLINK_HALF(BHALF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_digits(cpu_digits), .cpu_lock(cpu_lock),
    .hw_req(hw_req), .hw_digits(hw_digits), .hw_grant(hw_grant), .owner(owner),
    .digits_out(digits_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: which source is shown, and how long the current phase has lasted.
  typedef enum int {SHOW_CPU, BLANK_IN, SHOW_HW, BLANK_OUT} phase_t;
  phase_t       m_phase = SHOW_CPU;
  int           m_age = 0;
  logic [W-1:0] m_digits = BLANK;
  logic         m_grant = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase  <= SHOW_CPU;
      m_age    <= 0;
      m_digits <= BLANK;
      m_grant  <= 1'b0;
    end else begin
      case (m_phase)
        SHOW_CPU: begin
          m_digits <= cpu_digits;
          if (hw_req && !cpu_lock) begin m_phase <= BLANK_IN; m_age <= 0; end
        end
        BLANK_IN: begin
          m_digits <= BLANK;
          if (!hw_req) begin m_phase <= BLANK_OUT; m_age <= 0; end
          else if (m_age + 1 >= GAP) begin m_phase <= SHOW_HW; m_age <= 0; m_grant <= 1'b1; end
          else m_age <= m_age + 1;
        end
        SHOW_HW: begin
          m_digits <= (BLINK_ON && ((m_age / BHALF) % 2 == 1)) ? BLANK : hw_digits;
          if ((m_age + 1 >= HOLD) && !hw_req) begin
            m_phase <= BLANK_OUT; m_age <= 0; m_grant <= 1'b0;
          end else m_age <= m_age + 1;
        end
        default: begin
          m_digits <= BLANK;
          if (m_age + 1 >= GAP) begin m_phase <= SHOW_CPU; m_age <= 0; end
          else m_age <= m_age + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("digits_out", digits_out, m_digits);
    check("hw_grant", W'(hw_grant), W'(m_grant));
    check("owner", W'(owner), W'(m_grant));
  end

  logic [W-1:0] log_d [0:39];
  logic         log_g [0:39];

  // Run n cycles logging outputs; hw_req drops after cycle drop_at.
  task automatic run(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      log_d[i] = digits_out;
      log_g[i] = hw_grant;
      if (i == drop_at) hw_req = 1'b0;
    end
  endtask

  function automatic int count_d(input int n, input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < n; i++) if (log_d[i] == v) c++;
    return c;
  endfunction

  function automatic int count_g(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (log_g[i]) c++;
    return c;
  endfunction

  initial begin
    int bad;
    // 1: reset and release
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", digits_out, BLANK);
    check("rst_grant", W'(hw_grant), W'(1'b0));
    reset_n = 1'b1;
    @(negedge clk);
    check("release_cpu", digits_out, 24'h123456);
    repeat (2) @(negedge clk);

    // 2: short request -> gap, 8-cycle hold, gap, CPU
    hw_req = 1'b1;
    run(20, 3);
    check("t2_cpu_first", log_d[0], 24'h123456);
    check("t2_gap1", log_d[1], BLANK);
    check("t2_gap2", log_d[2], BLANK);
    check("t2_grant_rise", W'(log_g[2]), W'(1'b1));
    check("t2_first_hw", log_d[3], HW_PAT);
    check("t2_hw_cycles", W'(count_d(20, HW_PAT)), W'(8));
    check("t2_grant_cycles", W'(count_g(20)), W'(8));
    check("t2_gap_back", log_d[12], BLANK);
    check("t2_cpu_back", log_d[13], 24'h123456);

    // 3: long request, lock raised mid-grant is ignored
    cpu_digits = 24'h654321;
    repeat (2) @(negedge clk);
    hw_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      log_d[i] = digits_out;
      log_g[i] = hw_grant;
      if (i == 5) cpu_lock = 1'b1;
      if (i == 19) begin hw_req = 1'b0; cpu_lock = 1'b0; end
    end
    check("t3_grant_late", W'(log_g[19]), W'(1'b1));
    check("t3_grant_drop", W'(log_g[20]), W'(1'b0));
    check("t3_gap", log_d[22], BLANK);
    check("t3_cpu_back", log_d[23], 24'h654321);

    // 4: lock wins over simultaneous request, then abort in the gap
    repeat (2) @(negedge clk);
    cpu_lock = 1'b1;
    hw_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      log_d[i] = digits_out;
      log_g[i] = hw_grant;
      if (i == 9) cpu_lock = 1'b0;
      if (i == 11) hw_req = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 11; i++) if (log_d[i] != 24'h654321) bad++;
    check("t4_locked_cpu", W'(bad), W'(0));
    check("t4_no_grant", W'(count_g(16)), W'(0));
    check("t4_gap_start", log_d[11], BLANK);
    check("t4_abort_gap", log_d[14], BLANK);
    check("t4_cpu_back", log_d[15], 24'h654321);

    // 5: reset in the third HW_ACTIVE cycle
    repeat (2) @(negedge clk);
    hw_req = 1'b1;
    run(5, 99);
    check("t5_in_hw", W'(log_g[4]), W'(1'b1));
    #2 reset_n = 1'b0;
    hw_req = 1'b0;
    #1;
    check("t5_async_grant", W'(hw_grant), W'(1'b0));
    check("t5_async_digits", digits_out, BLANK);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("t5_no_gap", digits_out, 24'h654321);

    // 6: 16-cycle request, blink or steady depending on build
    repeat (2) @(negedge clk);
    hw_req = 1'b1;
    run(24, 15);
    check("t6_visible_start", log_d[3], HW_PAT);
    check("t6_visible_end", log_d[6], HW_PAT);
`ifdef DISPLAY_ARB_BLINK_EN
    check("t6_blank_phase", log_d[7], BLANK);
    check("t6_blank_end", log_d[10], BLANK);
    check("t6_visible_again", log_d[11], HW_PAT);
`else
    check("t6_steady", log_d[7], HW_PAT);
    check("t6_steady_late", log_d[15], HW_PAT);
`endif
    check("t6_grant_drop", W'(log_g[16]), W'(1'b0));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
